jtag_mem_data: RTL
==================

JTAG_MEM_DATA -- requirements
Module: jtag_mem_data

Interface
REQ-001 Parameter: DW, 64, memory data width; shift register width is DW+2.
REQ-002 TCK  in  1  JTAG clock; all logic on posedge TCK.
REQ-003 RESET  in  1  reset; synchronous, active-high.
REQ-004 SEL, CAPTURE, SHIFT, UPDATE  in  1 each  BSCAN user-chain controls for the data chain.
REQ-005 TDI  in  1  serial in.
REQ-006 TDO  out  1  serial out, equal to SR[0].
REQ-007 ADDR_IN  in  32  byte address from the address chain.
REQ-008 WR_IN, INC_IN  in  1 each  write mode and auto-increment mode from the address chain.
REQ-009 ADDR_LOAD  in  1  one-cycle pulse: address chain just updated.
REQ-010 INIT_IN  in  1  address-chain init sweep done; 0 means sweep in progress.
REQ-011 MEM_REQ, MEM_WE  out  1 each  memory request and write enable.
REQ-012 MEM_ADDR  out  32  memory byte address.
REQ-013 MEM_WDATA  out  DW  write data.
REQ-014 MEM_BE  out  DW/8  byte enables, always all ones.
REQ-015 MEM_GNT  in  1  request accepted this cycle.
REQ-016 MEM_RVALID, MEM_RDATA  in  1, DW  read response, 1+ cycles after grant.

Function
REQ-017 Internal state: SR[DW+1:0], PTR[31:0], RDATA_Q[DW-1:0], RD_VALID, OVR, PEND, FSM.
REQ-018 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-019 MEM_REQ=1 in RD_REQ and WR_REQ only; MEM_WE=1 in WR_REQ only; MEM_ADDR=PTR.
REQ-020 RD_REQ: on MEM_GNT go to RD_WAIT.
REQ-021 RD_WAIT: on MEM_RVALID, RDATA_Q<=MEM_RDATA and RD_VALID<=1; then go to RD_REQ if PEND (clear PEND, RD_VALID<=0), else IDLE.
REQ-022 WR_REQ: on MEM_GNT go to IDLE, and PTR<=PTR+8 if INC_IN.
REQ-023 Request hold: MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA stay stable until MEM_GNT.
REQ-024 ADDR_LOAD: PTR<=ADDR_IN, RD_VALID<=0, OVR<=0.
REQ-025 ADDR_LOAD with WR_IN=0: go to RD_REQ if IDLE; set PEND if in RD_REQ/RD_WAIT.
REQ-026 ADDR_LOAD in WR_REQ: PTR update is deferred until after the grant; the deferred load has priority over the increment.
REQ-027 SEL&CAPTURE: SR<={OVR, RD_VALID, RDATA_Q}.
REQ-028 SEL&SHIFT: SR<={TDI, SR[DW+1:1]}.
REQ-029 SEL&UPDATE with WR_IN=1 in IDLE: MEM_WDATA<=SR[DW-1:0], go to WR_REQ.
REQ-030 SEL&UPDATE with WR_IN=1 when not IDLE: write dropped, OVR<=1.
REQ-031 SEL&UPDATE with WR_IN=0 and INC_IN=1 in IDLE: PTR<=PTR+8, RD_VALID<=0, go to RD_REQ.
REQ-032 SEL&UPDATE with WR_IN=0 and INC_IN=1 when not IDLE: OVR<=1.
REQ-033 SEL&UPDATE with WR_IN=0 and INC_IN=0: no action.
REQ-034 PTR arithmetic is modulo 2^32; 32'hFFFFFFF8+8 wraps to 0.
REQ-035 Simultaneous ADDR_LOAD and UPDATE: ADDR_LOAD wins; UPDATE ignored.
REQ-036 While INIT_IN=0: FSM forced to and held in IDLE, MEM_REQ=0, ADDR_LOAD/UPDATE ignored; SHIFT/CAPTURE still operate.
REQ-037 Without SEL, CAPTURE/SHIFT/UPDATE have no effect.

Reset
REQ-038 RESET=1 at a TCK edge sets SR, PTR, RDATA_Q, MEM_WDATA, RD_VALID, OVR and PEND to 0 and FSM to IDLE.
REQ-039 Reset outputs: MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, TDO=0.
REQ-040 Reset overrides any outstanding request; a later MEM_RVALID is ignored until a new read is issued.

Verification
REQ-041 Read prefetch: INIT_IN=1, ADDR_IN=0x100, WR_IN=0, ADDR_LOAD -> MEM_REQ with MEM_ADDR=0x100, WE=0; RVALID with 0xDEADBEEF_CAFEF00D -> CAPTURE+shift yields data, RD_VALID=1, OVR=0.
REQ-042 Write with increment: WR_IN=1, INC_IN=1, load 0x200, shift 0x1122334455667788, UPDATE -> one write at 0x200 with that data; a second UPDATE writes at 0x208.
REQ-043 Read stream: WR_IN=0, INC_IN=1, three UPDATEs each after RVALID -> reads at A, A+8, A+16, A+24 in order.
REQ-044 Overrun: hold MEM_GNT=0, issue two write UPDATEs -> exactly one request; OVR=1 on capture; ADDR_LOAD clears OVR.
REQ-045 Boundaries: load 0xFFFFFFF8, INC read -> next MEM_ADDR=0. INIT_IN=0 with ADDR_LOAD -> MEM_REQ stays 0.
REQ-046 Reset mid-read: RESET during RD_WAIT -> MEM_REQ=0, RD_VALID=0; a later RVALID leaves RDATA_Q=0.

Source files
------------

// File: rtl/jtag_mem_data.sv
// jtag_mem_data: BSCAN user data chain bridging a DW+2 bit shift register to a simple
// req/gnt memory port, with read prefetch, auto-increment and overrun flagging.
module jtag_mem_data #(
    parameter int DW = 64
) (
    input  logic            TCK,
    input  logic            RESET,
    input  logic            SEL,
    input  logic            CAPTURE,
    input  logic            SHIFT,
    input  logic            UPDATE,
    input  logic            TDI,
    output logic            TDO,
    input  logic [31:0]     ADDR_IN,
    input  logic            WR_IN,
    input  logic            INC_IN,
    input  logic            ADDR_LOAD,
    input  logic            INIT_IN,
    output logic            MEM_REQ,
    output logic            MEM_WE,
    output logic [31:0]     MEM_ADDR,
    output logic [DW-1:0]   MEM_WDATA,
    output logic [DW/8-1:0] MEM_BE,
    input  logic            MEM_GNT,
    input  logic            MEM_RVALID,
    input  logic [DW-1:0]   MEM_RDATA
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
    state_t state, state_nxt;
    logic [DW+1:0] sr;
    logic [31:0]   ptr, ld_addr;
    logic [DW-1:0] rdata_q;
    logic          rd_valid, ovr, pend, ld_pend;
    logic          load, upd, idle, busy, rd_ret, pend_set, wr_upd, rd_upd;

    assign load     = ADDR_LOAD & INIT_IN;
    assign upd      = SEL & UPDATE & INIT_IN & ~ADDR_LOAD;
    assign idle     = state == IDLE;
    assign busy     = state == RD_REQ || state == WR_REQ;
    assign rd_ret   = INIT_IN && state == RD_WAIT && MEM_RVALID;
    assign pend_set = load & ~WR_IN & (state == RD_REQ || state == RD_WAIT);
    assign wr_upd   = upd & WR_IN & idle;
    assign rd_upd   = upd & ~WR_IN & INC_IN & idle;

    assign TDO       = sr[0];
    assign MEM_REQ   = INIT_IN & busy;
    assign MEM_WE    = INIT_IN & (state == WR_REQ);
    assign MEM_ADDR  = ptr;
    assign MEM_BE    = '1;

    always_comb begin
        state_nxt = state;
        if (!INIT_IN)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = wr_upd ? WR_REQ : (rd_upd || (load && !WR_IN)) ? RD_REQ : IDLE;
                RD_REQ:  state_nxt = MEM_GNT ? RD_WAIT : RD_REQ;
                RD_WAIT: state_nxt = !MEM_RVALID ? RD_WAIT : (pend || pend_set) ? RD_REQ : IDLE;
                WR_REQ:  state_nxt = MEM_GNT ? IDLE : WR_REQ;
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge TCK)
        state <= RESET ? IDLE : state_nxt;

    always_ff @(posedge TCK) begin
        if (RESET) begin
            sr        <= '0;
            ptr       <= '0;
            ld_addr   <= '0;
            rdata_q   <= '0;
            MEM_WDATA <= '0;
            rd_valid  <= 1'b0;
            ovr       <= 1'b0;
            pend      <= 1'b0;
            ld_pend   <= 1'b0;
        end else begin
            if (SEL && CAPTURE)
                sr <= {ovr, rd_valid, rdata_q};
            else if (SEL && SHIFT)
                sr <= {TDI, sr[DW+1:1]};
            if (!INIT_IN) begin
                pend    <= 1'b0;
                ld_pend <= 1'b0;
            end else begin
                // MEM_ADDR must hold while a request is up, so loads then wait for the grant
                if (busy && MEM_GNT) begin
                    ptr     <= load ? ADDR_IN : ld_pend ? ld_addr :
                               (state == WR_REQ && INC_IN) ? ptr + 32'd8 : ptr;
                    ld_pend <= 1'b0;
                end else if (load && busy) begin
                    ld_pend <= 1'b1;
                    ld_addr <= ADDR_IN;
                end else if (load)
                    ptr <= ADDR_IN;
                else if (rd_upd)
                    ptr <= ptr + 32'd8;
                if (load || rd_upd)
                    rd_valid <= 1'b0;
                else if (rd_ret)
                    rd_valid <= ~pend;
                if (load)
                    ovr <= 1'b0;
                else if (upd && !idle && (WR_IN || INC_IN))
                    ovr <= 1'b1;
                if (rd_ret)
                    rdata_q <= MEM_RDATA;
                if (rd_ret)
                    pend <= 1'b0;
                else if (pend_set)
                    pend <= 1'b1;
                if (wr_upd)
                    MEM_WDATA <= sr[DW-1:0];
            end
        end
    end
endmodule
